mem_stage_lsu: RTL

// MEM-stage load/store unit: consumes the decoded control_word_t for EX/MEM and issues exactly one data-memory transaction per memory op.

---
 rtl/mem_stage_lsu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: one data-port transaction per memory op.
// Handles byte lanes, load extension, stall, misalignment rejection, flush discard and timeout.
package mem_stage_lsu_pkg;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic [4:0] dest;
    logic       load_regfile;
  } control_word_t;
endpackage

module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  control_word_t cw_i,
  input  logic [31:0]   alu_out_i,
  input  logic [31:0]   rs2_data_i,
  input  logic          flush_i,
  output logic          data_read,
  output logic          data_write,
  output logic [3:0]    data_mbe,
  output logic [31:0]   data_addr,
  output logic [31:0]   data_wdata,
  input  logic [31:0]   data_rdata,
  input  logic          data_resp,
  output logic          stall_o,
  output logic          wb_valid_o,
  output logic [31:0]   wb_data_o,
  output logic [4:0]    wb_rd_o,
  output logic          wb_load_regfile_o,
  output logic          misaligned_o,
  output logic          timeout_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic [4:0]       r_dest;
  logic             r_is_load;
  logic             r_load_rf;
  logic             r_discard;
  logic             r_hold;

  logic [1:0]  w_off;
  logic        w_memop;
  logic        w_illegal;
  logic        w_live;
  logic        w_start;
  logic [3:0]  w_mbe;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  assign w_off   = alu_out_i[1:0];
  assign w_memop = cw_i.mem_read | cw_i.mem_write;

  always_comb begin
    w_illegal = 1'b0;
    if (cw_i.mem_read && cw_i.mem_write) begin
      w_illegal = 1'b1;
    end else if (cw_i.mem_read) begin
      case (cw_i.funct3)
        3'b000, 3'b100: w_illegal = 1'b0;
        3'b001, 3'b101: w_illegal = w_off[0];
        3'b010:         w_illegal = |w_off;
        default:        w_illegal = 1'b1;
      endcase
    end else if (cw_i.mem_write) begin
      case (cw_i.funct3)
        3'b000:  w_illegal = 1'b0;
        3'b001:  w_illegal = w_off[0];
        3'b010:  w_illegal = |w_off;
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // The instruction that just completed is still presented for one cycle
  // (it was stalled); r_hold keeps it from being issued a second time.
  assign w_live  = valid_i & ~flush_i & (r_state == S_IDLE) & ~r_hold;
  assign w_start = w_live & w_memop & ~w_illegal;
  assign stall_o = w_start | (r_state == S_BUSY);

  always_comb begin
    w_mbe = 4'b1111;
    case (cw_i.funct3[1:0])
      2'b00:   w_mbe = 4'b0001 << w_off;
      2'b01:   w_mbe = 4'b0011 << w_off;
      default: w_mbe = 4'b1111;
    endcase
  end

  assign w_wdata = rs2_data_i << {w_off, 3'b000};
  assign w_byte  = data_rdata[{r_off, 3'b000} +: 8];
  assign w_half  = data_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_val = data_rdata;
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = data_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_funct3          <= 3'd0;
      r_off             <= 2'd0;
      r_dest            <= 5'd0;
      r_is_load         <= 1'b0;
      r_load_rf         <= 1'b0;
      r_discard         <= 1'b0;
      r_hold            <= 1'b0;
      data_read         <= 1'b0;
      data_write        <= 1'b0;
      data_mbe          <= 4'd0;
      data_addr         <= 32'd0;
      data_wdata        <= 32'd0;
      wb_valid_o        <= 1'b0;
      wb_data_o         <= 32'd0;
      wb_rd_o           <= 5'd0;
      wb_load_regfile_o <= 1'b0;
      misaligned_o      <= 1'b0;
      timeout_o         <= 1'b0;
    end else begin
      wb_valid_o        <= 1'b0;
      wb_load_regfile_o <= 1'b0;
      misaligned_o      <= w_live & w_memop & w_illegal;
      r_hold            <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_state    <= S_BUSY;
          r_cnt      <= '0;
          r_funct3   <= cw_i.funct3;
          r_off      <= w_off;
          r_dest     <= cw_i.dest;
          r_is_load  <= cw_i.mem_read;
          r_load_rf  <= cw_i.mem_read & cw_i.load_regfile;
          r_discard  <= 1'b0;
          data_read  <= cw_i.mem_read;
          data_write <= cw_i.mem_write;
          data_mbe   <= w_mbe;
          data_addr  <= {alu_out_i[31:2], 2'b00};
          data_wdata <= w_wdata;
        end
      end else begin
        if (flush_i) r_discard <= 1'b1;
        if (data_resp) begin
          r_state           <= S_IDLE;
          r_hold            <= 1'b1;
          data_read         <= 1'b0;
          data_write        <= 1'b0;
          wb_valid_o        <= ~(r_discard | flush_i);
          wb_load_regfile_o <= r_load_rf & ~(r_discard | flush_i);
          wb_data_o         <= r_is_load ? w_load_val : 32'd0;
          wb_rd_o           <= r_dest;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
          r_state    <= S_IDLE;
          r_hold     <= 1'b1;
          data_read  <= 1'b0;
          data_write <= 1'b0;
          timeout_o  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
